instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage sitting directly downstream of `program_counter`. It accepts each new PC value, issues a request to instruction memory over a request/grant/response handshake and holds the returned instruction with its PC for the decode stage until decode consumes it. It supports flush for redirects and keeps a delivered-instruction counter.

## Interface
- `DATA_W`, 32: instruction and memory data width.
- `ADDR_W`, 32: PC and memory address width.
- `clk`  in  1  single clock. All state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pc_in`  in  ADDR_W  PC value from the program counter.
- `pc_valid`  in  1  `pc_in` is a new fetch address.
- `pc_ready`  out  1  fetch unit accepts `pc_in` this cycle.
- `flush`  in  1  discard any in-flight or held fetch.
- `imem_req`  out  1  memory request.
- `imem_addr`  out  ADDR_W  request address, word-aligned.
- `imem_gnt`  in  1  memory accepted the request.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  DATA_W  response data.
- `if_valid`  out  1  `if_instr`/`if_pc` valid to decode.
- `if_instr`  out  DATA_W  fetched instruction.
- `if_pc`  out  ADDR_W  PC of `if_instr`.
- `if_ready`  in  1  decode consumes the held instruction.
- `misalign_fault`  out  1  held entry is a misalignment fault. Tied 0 without the macro.
- `fetch_count`  out  32  number of instructions delivered.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, DRAIN. Reset state is IDLE.
- Accept condition: `pc_ready = !flush && (state==IDLE || (state==HOLD && if_ready))`. `pc_ready` is combinational.
- Accept handshake: `pc_valid && pc_ready`. This latches the address register with `{pc_in[ADDR_W-1:2],2'b00}` and moves to REQ.
- REQ:
  - `imem_req=1` and `imem_addr` = address register.
  - On `imem_gnt`, go to WAIT.
  - Otherwise hold the request stable.
- WAIT:
  - On `imem_rvalid`, capture `imem_rdata` into `if_instr` and the address into `if_pc`, set `if_valid`, go to HOLD.
  - `imem_rvalid` is ignored in every state except WAIT and DRAIN.
- HOLD:
  - `if_valid=1`.
  - On `if_ready`, `fetch_count` increments by 1 and wraps from 0xFFFFFFFF to 0.
  - Next state is REQ if a new PC is accepted in the same cycle, otherwise IDLE.
- Flush has the highest priority:
  - IDLE: stays IDLE, and `pc_valid` is ignored.
  - REQ: `imem_req` drops the next cycle and the state goes to IDLE. A grant in the same cycle as the flush is treated as accepted, so the state goes to DRAIN.
  - WAIT: goes to DRAIN.
  - HOLD: `if_valid` clears and the state goes to IDLE. No count increment, even if `if_ready` is high.
- DRAIN: `pc_ready=0`. On `imem_rvalid`, the data is discarded and the state goes to IDLE.
- Only one memory transaction is ever outstanding.

## Timing
- Reset values:
  - `imem_req=0`, `imem_addr=0`
  - `if_valid=0`, `if_instr=0`, `if_pc=0`
  - `misalign_fault=0`, `fetch_count=0`
- All outputs except `pc_ready` are registered.
- Minimum latency is 3 cycles from accept to `if_valid`, with zero-wait memory:
  - accept at edge 0
  - REQ in cycle 1 with `imem_gnt`
  - WAIT in cycle 2 with `imem_rvalid`
  - `if_valid` in cycle 3
- Memory contract: `imem_rvalid` arrives at least one cycle after `imem_gnt`.
- Back-to-back throughput is one instruction per 3 cycles.
- Reset assertion mid-transaction returns to IDLE immediately. A late `imem_rvalid` after reset is ignored.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - An accepted PC with `pc_in[1:0]!=0` issues no memory request.
  - The next cycle enters HOLD with `if_instr=0` (NOP), `if_pc=pc_in` unmodified, and `misalign_fault=1`.
  - The entry is consumed via `if_ready` like a normal entry and counts in `fetch_count`.
  - `misalign_fault` clears when the entry is consumed or flushed.
- `FETCH_MISALIGN_CHECK_EN` undefined:
  - The low two PC bits are silently forced to 0.
  - `misalign_fault` is constant 0.

## Test plan
- Basic fetch: zero-wait memory, `imem_rdata=0x8C080004`, PC 0x100 accepted at cycle 0 -> `imem_addr=0x100` in cycle 1, `if_valid=1`, `if_instr=0x8C080004`, `if_pc=0x100` in cycle 3.
- Stalls: `imem_gnt` delayed 2 cycles, `if_ready` low 4 cycles -> `imem_req`/`imem_addr` stable while waiting, `if_*` stable during hold, `fetch_count` 0 -> 1 only on the consume cycle.
- Back-to-back: 5 PCs 0x0 to 0x10 step 4, `if_ready` always high -> 5 deliveries in order, new PC accepted in HOLD, `fetch_count=5`.
- Flush in WAIT: `flush` 1 cycle, then `imem_rvalid` with 0xDEADBEEF -> `if_valid` never rises, `pc_ready=0` until rvalid, then IDLE, count unchanged.
- Flush in HOLD with `if_ready=1` -> `if_valid` clears, count unchanged, a PC offered in the same cycle is not accepted.
- Misaligned PC 0x102 (macro on) -> no `imem_req`, `if_valid=1`, `if_instr=0`, `if_pc=0x102`, `misalign_fault=1`. Macro off -> request at 0x100.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: PC handshake, instruction-memory handshake and decode-side outputs.
// master = fetch unit, slave = surrounding pipeline / memory.
interface instr_fetch_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pc_in;
  logic              pc_valid;
  logic              pc_ready;
  logic              flush;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              if_ready;
  logic              misalign_fault;
  logic [31:0]       fetch_count;

  modport master (
    input  pc_in, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    output pc_ready, imem_req, imem_addr, if_valid, if_instr, if_pc,
           misalign_fault, fetch_count
  );

  modport slave (
    output pc_in, pc_valid, flush, imem_gnt, imem_rvalid, imem_rdata, if_ready,
    input  pc_ready, imem_req, imem_addr, if_valid, if_instr, if_pc,
           misalign_fault, fetch_count
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one outstanding imem transaction, holds the result for decode.
// Optional FETCH_MISALIGN_CHECK_EN turns misaligned PCs into NOP fault entries instead of masking.
module instr_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              imem_req_q, imem_req_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] if_instr_q, if_instr_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic              misalign_q, misalign_d;
  logic [31:0]       fetch_count_q, fetch_count_d;
  logic              pc_ready;
  logic              accept;

  // A held entry can be replaced in the same cycle decode takes it.
  assign pc_ready = !bus.flush && (state_q == IDLE || (state_q == HOLD && bus.if_ready));
  assign accept   = bus.pc_valid && pc_ready;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    imem_req_d    = imem_req_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    misalign_d    = misalign_q;
    fetch_count_d = fetch_count_q;

    case (state_q)
      IDLE: ;
      REQ: begin
        // A grant coinciding with flush still owes us a response, so drain it.
        if (bus.flush) begin
          imem_req_d = 1'b0;
          state_d    = bus.imem_gnt ? DRAIN : IDLE;
        end else if (bus.imem_gnt) begin
          imem_req_d = 1'b0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (bus.flush) begin
          state_d = DRAIN;
        end else if (bus.imem_rvalid) begin
          if_valid_d = 1'b1;
          if_instr_d = bus.imem_rdata;
          if_pc_d    = addr_q;
          misalign_d = 1'b0;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (bus.flush) begin
          if_valid_d = 1'b0;
          misalign_d = 1'b0;
          state_d    = IDLE;
        end else if (bus.if_ready) begin
          if_valid_d    = 1'b0;
          misalign_d    = 1'b0;
          fetch_count_d = fetch_count_q + 32'd1;
          state_d       = IDLE;
        end
      end
      DRAIN: begin
        if (bus.imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
`ifdef FETCH_MISALIGN_CHECK_EN
      if (bus.pc_in[1:0] != 2'b00) begin
        if_valid_d = 1'b1;
        if_instr_d = '0;
        if_pc_d    = bus.pc_in;
        misalign_d = 1'b1;
        state_d    = HOLD;
      end else begin
        addr_d     = bus.pc_in;
        imem_req_d = 1'b1;
        state_d    = REQ;
      end
`else
      addr_d     = bus.pc_in & ~ADDR_W'(3);
      imem_req_d = 1'b1;
      state_d    = REQ;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      imem_req_q    <= 1'b0;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      misalign_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      imem_req_q    <= imem_req_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.pc_ready       = pc_ready;
  assign bus.imem_req       = imem_req_q;
  assign bus.imem_addr      = addr_q;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_instr       = if_instr_q;
  assign bus.if_pc          = if_pc_q;
  assign bus.misalign_fault = misalign_q;
  assign bus.fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: inputs driven and outputs sampled on the falling edge.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [31:0] exp_count = 32'd0;

  instr_fetch_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  instr_fetch #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.pc_in = '0; bus.pc_valid = 1'b0; bus.flush = 1'b0; bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.if_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_imem_req: got %0h want 0", bus.imem_req); end
    n_chk++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_imem_addr: got %0h want 0", bus.imem_addr); end
    n_chk++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_if_valid: got %0h want 0", bus.if_valid); end
    n_chk++; if (bus.if_instr !== 32'h0) begin n_fail++; $display("FAIL rst_if_instr: got %0h want 0", bus.if_instr); end
    n_chk++; if (bus.if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_if_pc: got %0h want 0", bus.if_pc); end
    n_chk++; if (bus.misalign_fault !== 1'b0) begin n_fail++; $display("FAIL rst_misalign: got %0h want 0", bus.misalign_fault); end
    n_chk++; if (bus.fetch_count !== 32'h0) begin n_fail++; $display("FAIL rst_count: got %0h want 0", bus.fetch_count); end
    n_chk++; if (bus.pc_ready !== 1'b1) begin n_fail++; $display("FAIL rst_pc_ready: got %0h want 1", bus.pc_ready); end
    rst_n = 1'b1;
    exp_count = 32'd0;
  endtask

  task automatic test_basic();
    bus.pc_in = 32'h100; bus.pc_valid = 1'b1;
    #1;
    n_chk++; if (bus.pc_ready !== 1'b1) begin n_fail++; $display("FAIL basic_pc_ready: got %0h want 1", bus.pc_ready); end
    @(negedge clk);
    bus.pc_valid = 1'b0;
    n_chk++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL basic_req: got %0h want 1", bus.imem_req); end
    n_chk++; if (bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL basic_addr: got %0h want 100", bus.imem_addr); end
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0;
    n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_drop: got %0h want 0", bus.imem_req); end
    n_chk++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %0h want 0", bus.if_valid); end
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h8C080004;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    n_chk++; if (bus.if_valid !== 1'b1) begin n_fail++; $display("FAIL basic_if_valid: got %0h want 1", bus.if_valid); end
    n_chk++; if (bus.if_instr !== 32'h8C080004) begin n_fail++; $display("FAIL basic_if_instr: got %0h want 8c080004", bus.if_instr); end
    n_chk++; if (bus.if_pc !== 32'h100) begin n_fail++; $display("FAIL basic_if_pc: got %0h want 100", bus.if_pc); end
    bus.if_ready = 1'b1;
    @(negedge clk);
    bus.if_ready = 1'b0;
    exp_count = exp_count + 32'd1;
    n_chk++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL basic_consumed: got %0h want 0", bus.if_valid); end
    n_chk++; if (bus.fetch_count !== exp_count) begin n_fail++; $display("FAIL basic_count: got %0h want %0h", bus.fetch_count, exp_count); end
  endtask

  task automatic test_stalls();
    bus.pc_in = 32'h200; bus.pc_valid = 1'b1;
    @(negedge clk);
    bus.pc_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL stall_req[%0d]: got %0h want 1", k, bus.imem_req); end
      n_chk++; if (bus.imem_addr !== 32'h200) begin n_fail++; $display("FAIL stall_addr[%0d]: got %0h want 200", k, bus.imem_addr); end
      bus.imem_gnt = (k == 2);
      @(negedge clk);
    end
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h12345678;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_chk++; if (bus.if_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold_valid[%0d]: got %0h want 1", k, bus.if_valid); end
      n_chk++; if (bus.if_instr !== 32'h12345678) begin n_fail++; $display("FAIL stall_hold_instr[%0d]: got %0h want 12345678", k, bus.if_instr); end
      n_chk++; if (bus.if_pc !== 32'h200) begin n_fail++; $display("FAIL stall_hold_pc[%0d]: got %0h want 200", k, bus.if_pc); end
      n_chk++; if (bus.fetch_count !== exp_count) begin n_fail++; $display("FAIL stall_hold_count[%0d]: got %0h want %0h", k, bus.fetch_count, exp_count); end
      bus.if_ready = (k == 4);
      @(negedge clk);
    end
    bus.if_ready = 1'b0;
    exp_count = exp_count + 32'd1;
    n_chk++; if (bus.fetch_count !== exp_count) begin n_fail++; $display("FAIL stall_count: got %0h want %0h", bus.fetch_count, exp_count); end
    n_chk++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL stall_consumed: got %0h want 0", bus.if_valid); end
  endtask

  task automatic test_flush_wait();
    bus.pc_in = 32'h300; bus.pc_valid = 1'b1;
    @(negedge clk);
    bus.pc_valid = 1'b0; bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0; bus.flush = 1'b1;
    #1;
    n_chk++; if (bus.pc_ready !== 1'b0) begin n_fail++; $display("FAIL fw_ready_flush: got %0h want 0", bus.pc_ready); end
    @(negedge clk);
    bus.flush = 1'b0; bus.pc_in = 32'h400; bus.pc_valid = 1'b1;
    #1;
    n_chk++; if (bus.pc_ready !== 1'b0) begin n_fail++; $display("FAIL fw_ready_drain: got %0h want 0", bus.pc_ready); end
    n_chk++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL fw_valid_drain: got %0h want 0", bus.if_valid); end
    @(negedge clk);
    n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL fw_no_req: got %0h want 0", bus.imem_req); end
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEADBEEF;
    #1;
    n_chk++; if (bus.pc_ready !== 1'b0) begin n_fail++; $display("FAIL fw_ready_rvalid: got %0h want 0", bus.pc_ready); end
    @(negedge clk);
    bus.imem_rvalid = 1'b0; bus.pc_valid = 1'b0;
    #1;
    n_chk++; if (bus.pc_ready !== 1'b1) begin n_fail++; $display("FAIL fw_ready_idle: got %0h want 1", bus.pc_ready); end
    n_chk++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL fw_valid_after: got %0h want 0", bus.if_valid); end
    n_chk++; if (bus.fetch_count !== exp_count) begin n_fail++; $display("FAIL fw_count: got %0h want %0h", bus.fetch_count, exp_count); end
    @(negedge clk);
    n_chk++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL fw_valid_late: got %0h want 0", bus.if_valid); end
  endtask

  task automatic test_flush_req();
    bus.pc_in = 32'h700; bus.pc_valid = 1'b1;
    @(negedge clk);
    bus.pc_valid = 1'b0; bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL fr_req_drop: got %0h want 0", bus.imem_req); end
    #1;
    n_chk++; if (bus.pc_ready !== 1'b1) begin n_fail++; $display("FAIL fr_idle_ready: got %0h want 1", bus.pc_ready); end
    bus.pc_in = 32'h704; bus.pc_valid = 1'b1;
    @(negedge clk);
    bus.pc_valid = 1'b0; bus.flush = 1'b1; bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0; bus.imem_gnt = 1'b0;
    n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL fr_gnt_req: got %0h want 0", bus.imem_req); end
    #1;
    n_chk++; if (bus.pc_ready !== 1'b0) begin n_fail++; $display("FAIL fr_gnt_drain: got %0h want 0", bus.pc_ready); end
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00000BAD;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    #1;
    n_chk++; if (bus.pc_ready !== 1'b1) begin n_fail++; $display("FAIL fr_gnt_idle: got %0h want 1", bus.pc_ready); end
    n_chk++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL fr_gnt_valid: got %0h want 0", bus.if_valid); end
    @(negedge clk);
  endtask

  task automatic test_flush_hold();
    bus.pc_in = 32'h500; bus.pc_valid = 1'b1;
    @(negedge clk);
    bus.pc_valid = 1'b0; bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00000055;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    n_chk++; if (bus.if_valid !== 1'b1) begin n_fail++; $display("FAIL fh_valid: got %0h want 1", bus.if_valid); end
    bus.flush = 1'b1; bus.if_ready = 1'b1; bus.pc_in = 32'h600; bus.pc_valid = 1'b1;
    #1;
    n_chk++; if (bus.pc_ready !== 1'b0) begin n_fail++; $display("FAIL fh_ready: got %0h want 0", bus.pc_ready); end
    @(negedge clk);
    bus.flush = 1'b0; bus.if_ready = 1'b0; bus.pc_valid = 1'b0;
    n_chk++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL fh_cleared: got %0h want 0", bus.if_valid); end
    n_chk++; if (bus.fetch_count !== exp_count) begin n_fail++; $display("FAIL fh_count: got %0h want %0h", bus.fetch_count, exp_count); end
    n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL fh_no_accept: got %0h want 0", bus.imem_req); end
    @(negedge clk);
    n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL fh_still_idle: got %0h want 0", bus.imem_req); end
  endtask

  task automatic test_misalign();
    bus.pc_in = 32'h102; bus.pc_valid = 1'b1;
    @(negedge clk);
    bus.pc_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL ma_no_req: got %0h want 0", bus.imem_req); end
    n_chk++; if (bus.if_valid !== 1'b1) begin n_fail++; $display("FAIL ma_valid: got %0h want 1", bus.if_valid); end
    n_chk++; if (bus.if_instr !== 32'h0) begin n_fail++; $display("FAIL ma_instr: got %0h want 0", bus.if_instr); end
    n_chk++; if (bus.if_pc !== 32'h102) begin n_fail++; $display("FAIL ma_pc: got %0h want 102", bus.if_pc); end
    n_chk++; if (bus.misalign_fault !== 1'b1) begin n_fail++; $display("FAIL ma_fault: got %0h want 1", bus.misalign_fault); end
`else
    n_chk++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL ma_req: got %0h want 1", bus.imem_req); end
    n_chk++; if (bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL ma_addr: got %0h want 100", bus.imem_addr); end
    n_chk++; if (bus.misalign_fault !== 1'b0) begin n_fail++; $display("FAIL ma_fault_off: got %0h want 0", bus.misalign_fault); end
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00000013;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    n_chk++; if (bus.if_pc !== 32'h100) begin n_fail++; $display("FAIL ma_pc_off: got %0h want 100", bus.if_pc); end
    n_chk++; if (bus.if_instr !== 32'h13) begin n_fail++; $display("FAIL ma_instr_off: got %0h want 13", bus.if_instr); end
`endif
    bus.if_ready = 1'b1;
    @(negedge clk);
    bus.if_ready = 1'b0;
    exp_count = exp_count + 32'd1;
    n_chk++; if (bus.misalign_fault !== 1'b0) begin n_fail++; $display("FAIL ma_fault_clear: got %0h want 0", bus.misalign_fault); end
    n_chk++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL ma_consumed: got %0h want 0", bus.if_valid); end
    n_chk++; if (bus.fetch_count !== exp_count) begin n_fail++; $display("FAIL ma_count: got %0h want %0h", bus.fetch_count, exp_count); end
  endtask

  task automatic test_reset_mid();
    bus.pc_in = 32'h800; bus.pc_valid = 1'b1;
    @(negedge clk);
    bus.pc_valid = 1'b0;
    n_chk++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rm_req: got %0h want 1", bus.imem_req); end
    rst_n = 1'b0;
    #1;
    exp_count = 32'd0;
    n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rm_req_async: got %0h want 0", bus.imem_req); end
    n_chk++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL rm_addr_async: got %0h want 0", bus.imem_addr); end
    n_chk++; if (bus.fetch_count !== exp_count) begin n_fail++; $display("FAIL rm_count_async: got %0h want 0", bus.fetch_count); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h0000FEED;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    n_chk++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL rm_late_rvalid: got %0h want 0", bus.if_valid); end
    n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rm_idle_req: got %0h want 0", bus.imem_req); end
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 32'd0;
    for (int i = 0; i < 5; i++) begin
      bus.imem_rvalid = 1'b0;
      bus.pc_in = 32'(4 * i); bus.pc_valid = 1'b1; bus.if_ready = 1'b1;
      if (i > 0) begin
        n_chk++; if (bus.if_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %0h want 1", i - 1, bus.if_valid); end
        n_chk++; if (bus.if_pc !== 32'(4 * (i - 1))) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %0h want %0h", i - 1, bus.if_pc, 4 * (i - 1)); end
        n_chk++; if (bus.if_instr !== 32'hA0000000 + 32'(i - 1)) begin n_fail++; $display("FAIL b2b_instr[%0d]: got %0h", i - 1, bus.if_instr); end
        n_chk++; if (bus.fetch_count !== 32'(i - 1)) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0h want %0h", i - 1, bus.fetch_count, i - 1); end
      end
      #1;
      n_chk++; if (bus.pc_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %0h want 1", i, bus.pc_ready); end
      @(negedge clk);
      bus.pc_valid = 1'b0;
      n_chk++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req[%0d]: got %0h want 1", i, bus.imem_req); end
      n_chk++; if (bus.imem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL b2b_addr[%0d]: got %0h want %0h", i, bus.imem_addr, 4 * i); end
      bus.imem_gnt = 1'b1;
      @(negedge clk);
      bus.imem_gnt = 1'b0;
      bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hA0000000 + 32'(i);
      @(negedge clk);
    end
    bus.imem_rvalid = 1'b0;
    n_chk++; if (bus.if_pc !== 32'h10) begin n_fail++; $display("FAIL b2b_last_pc: got %0h want 10", bus.if_pc); end
    bus.if_ready = 1'b1;
    @(negedge clk);
    bus.if_ready = 1'b0;
    exp_count = 32'd5;
    n_chk++; if (bus.fetch_count !== exp_count) begin n_fail++; $display("FAIL b2b_total: got %0h want %0h", bus.fetch_count, exp_count); end
    n_chk++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %0h want 0", bus.if_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_flush_wait();
    test_flush_req();
    test_flush_hold();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
